// File: rtl/rx_align_pkg.sv
// rx_align_pkg: shared types and constants for the Rx 66b block-alignment path.
package rx_align_pkg;

   // Block-lock sequencer states; the encoding is exported on state_o.
   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      SETTLE = 2'd1,
      VERIFY = 2'd2,
      LOCKED = 2'd3
   } lock_state_e;

   localparam logic [1:0] DATA_HEADER = 2'b01;
   localparam logic [1:0] CMD_HEADER  = 2'b10;
   localparam int         BLOCK_BITS  = 66;
   localparam logic [6:0] MAX_OFFSET  = 7'd65;

   // A 66b sync header is legal only as 01 (data) or 10 (control).
   function automatic logic hdr_is_valid(input logic [1:0] hdr);
      return (hdr == DATA_HEADER) || (hdr == CMD_HEADER);
   endfunction

endpackage

// File: rtl/hdr_err_window.sv
// hdr_err_window: counts bad sync headers over fixed windows of WIN_LEN blocks
// and flags loss when MAX_BAD of them land in one window. WIN_LEN must be a
// power of two so the block counter wraps on its own.
module hdr_err_window #(
   parameter int WIN_LEN = 64,
   parameter int MAX_BAD = 16
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clear_i,
   input  logic hdr_dv_i,
   input  logic hdr_bad_i,
   output logic loss_o
);
   localparam int BLK_W = $clog2(WIN_LEN);
   localparam int BAD_W = $clog2(MAX_BAD + 1);
   localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(WIN_LEN - 1);
   localparam logic [BAD_W-1:0] BAD_LIMIT = BAD_W'(MAX_BAD);

   logic [BLK_W-1:0] blk_cnt_q;
   logic [BAD_W-1:0] bad_cnt_q;
   logic [BAD_W-1:0] bad_cnt_inc;
   logic             win_end;

   // Saturating increment, window-end detect and loss flag; a bad header on the
   // last block of a window is judged before the window clears.
   always_comb begin
      bad_cnt_inc = (bad_cnt_q == BAD_LIMIT) ? bad_cnt_q : bad_cnt_q + 1'b1;
      win_end     = hdr_dv_i && (blk_cnt_q == BLK_LAST);
      loss_o      = !clear_i && hdr_dv_i && hdr_bad_i && (bad_cnt_inc == BAD_LIMIT);
   end

   // Block position within the window and bad-header tally for that window.
   // NOTE: state registers use <= so every flop samples pre-edge values.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         blk_cnt_q <= '0;
         bad_cnt_q <= '0;
      end else if (clear_i) begin
         blk_cnt_q <= '0;
         bad_cnt_q <= '0;
      end else if (hdr_dv_i) begin
         blk_cnt_q <= blk_cnt_q + 1'b1;
         if (win_end)        bad_cnt_q <= '0;
         else if (hdr_bad_i) bad_cnt_q <= bad_cnt_inc;
      end
   end

endmodule

// File: rtl/block_lock_ctrl.sv
// block_lock_ctrl: qualifies the seeker offset, loads it into the 66b extractor,
// verifies headers, declares block lock and drops it on excessive header errors.
// Build macro BLOCK_LOCK_STATS_EN adds a lock-loss counter on relock_cnt_o and an
// internal bad-header total; without it relock_cnt_o is tied to zero.
module block_lock_ctrl
   import rx_align_pkg::*;
#(
   parameter int STABLE_CNT = 8,
   parameter int SETTLE_CYC = 4,
   parameter int VERIFY_CNT = 32,
   parameter int WIN_LEN    = 64,
   parameter int MAX_BAD    = 16
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        seek_dv_i,
   input  logic [6:0]  seek_offset_i,
   input  logic        hdr_dv_i,
   input  logic [1:0]  hdr_i,
   input  logic        force_relock_i,
   output logic [6:0]  offset_o,
   output logic        offset_load_o,
   output logic        locked_o,
   output logic [1:0]  state_o,
   output logic [15:0] relock_cnt_o
);
   localparam int STAB_W = $clog2(STABLE_CNT + 1);
   localparam int SETL_W = $clog2(SETTLE_CYC + 1);
   localparam int GOOD_W = $clog2(VERIFY_CNT + 1);
   localparam logic [STAB_W-1:0] STAB_DONE = STAB_W'(STABLE_CNT);
   localparam logic [SETL_W-1:0] SETL_LAST = SETL_W'(SETTLE_CYC - 1);
   localparam logic [GOOD_W-1:0] GOOD_DONE = GOOD_W'(VERIFY_CNT);

   lock_state_e       state_q, state_d;
   logic [6:0]        cand_q, cand_d;
   logic [6:0]        offset_q, offset_d;
   logic [STAB_W-1:0] stab_cnt_q, stab_cnt_d;
   logic [SETL_W-1:0] settle_cnt_q, settle_cnt_d;
   logic [GOOD_W-1:0] good_cnt_q, good_cnt_d;
   logic              load_q, load_d;
   logic              hdr_ok;
   logic              win_clear;
   logic              win_loss;

   assign hdr_ok    = hdr_is_valid(hdr_i);
   // The error window only runs while locked; it restarts on every lock entry.
   assign win_clear = (state_q != LOCKED) || force_relock_i;

   hdr_err_window #(
      .WIN_LEN (WIN_LEN),
      .MAX_BAD (MAX_BAD)
   ) u_hdr_err_window (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .clear_i   (win_clear),
      .hdr_dv_i  (hdr_dv_i),
      .hdr_bad_i (!hdr_ok),
      .loss_o    (win_loss)
   );

   // Next-state logic; per-state counters fall back to zero outside their state.
   // NOTE: every signal assigned here gets a default first, so no latch is inferred.
   always_comb begin
      state_d      = state_q;
      cand_d       = cand_q;
      offset_d     = offset_q;
      stab_cnt_d   = '0;
      settle_cnt_d = '0;
      good_cnt_d   = '0;
      load_d       = 1'b0;

      unique case (state_q)
         HUNT: begin
            stab_cnt_d = stab_cnt_q;
            if (seek_dv_i) begin
               if (seek_offset_i > MAX_OFFSET) begin
                  stab_cnt_d = '0;
               end else if (seek_offset_i == cand_q) begin
                  stab_cnt_d = (stab_cnt_q == STAB_DONE) ? stab_cnt_q : stab_cnt_q + 1'b1;
               end else begin
                  cand_d     = seek_offset_i;
                  stab_cnt_d = STAB_W'(1);
               end
               if (stab_cnt_d == STAB_DONE) begin
                  offset_d   = cand_d;
                  load_d     = 1'b1;
                  stab_cnt_d = '0;
                  state_d    = SETTLE;
               end
            end
         end
         SETTLE: begin
            if (settle_cnt_q == SETL_LAST) state_d = VERIFY;
            else                           settle_cnt_d = settle_cnt_q + 1'b1;
         end
         VERIFY: begin
            good_cnt_d = good_cnt_q;
            if (hdr_dv_i) begin
               if (hdr_ok) begin
                  good_cnt_d = (good_cnt_q == GOOD_DONE) ? good_cnt_q : good_cnt_q + 1'b1;
                  if (good_cnt_d == GOOD_DONE) begin
                     good_cnt_d = '0;
                     state_d    = LOCKED;
                  end
               end else begin
                  good_cnt_d = '0;
                  state_d    = HUNT;
               end
            end
         end
         LOCKED: begin
            if (win_loss) state_d = HUNT;
         end
      endcase

      // A software relock overrides everything: no load, counters cleared.
      if (force_relock_i) begin
         state_d      = HUNT;
         cand_d       = cand_q;
         offset_d     = offset_q;
         stab_cnt_d   = '0;
         settle_cnt_d = '0;
         good_cnt_d   = '0;
         load_d       = 1'b0;
      end
   end

   // State, candidate, applied offset, per-state counters and the load pulse.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= HUNT;
         cand_q       <= '0;
         offset_q     <= '0;
         stab_cnt_q   <= '0;
         settle_cnt_q <= '0;
         good_cnt_q   <= '0;
         load_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cand_q       <= cand_d;
         offset_q     <= offset_d;
         stab_cnt_q   <= stab_cnt_d;
         settle_cnt_q <= settle_cnt_d;
         good_cnt_q   <= good_cnt_d;
         load_q       <= load_d;
      end
   end

   assign offset_o      = offset_q;
   assign offset_load_o = load_q;
   assign locked_o      = (state_q == LOCKED);
   assign state_o       = state_q;

`ifdef BLOCK_LOCK_STATS_EN
   logic [15:0] relock_cnt_q;
   logic [15:0] bad_total_q;
   logic        lock_lost;
   logic        hdr_used;

   assign lock_lost = (state_q == LOCKED) && (state_d == HUNT);
   assign hdr_used  = hdr_dv_i && ((state_q == VERIFY) || (state_q == LOCKED));

   // Saturating lock-loss count and debug total of bad headers seen at the applied offset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         relock_cnt_q <= '0;
         bad_total_q  <= '0;
      end else begin
         if (lock_lost && (relock_cnt_q != 16'hFFFF)) relock_cnt_q <= relock_cnt_q + 1'b1;
         if (hdr_used && !hdr_ok && (bad_total_q != 16'hFFFF)) bad_total_q <= bad_total_q + 1'b1;
      end
   end

   assign relock_cnt_o = relock_cnt_q;
`else
   assign relock_cnt_o = '0;
`endif

endmodule

// File: tb/tb_block_lock_ctrl.sv
// tb_block_lock_ctrl: randomized stimulus with a cycle-level reference model;
// expected outputs are queued by the driver and consumed by an independent monitor.
module tb_block_lock_ctrl;
   localparam int STABLE_CNT = 8;
   localparam int SETTLE_CYC = 4;
   localparam int VERIFY_CNT = 32;
   localparam int WIN_LEN    = 64;
   localparam int MAX_BAD    = 16;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        seek_dv_i;
   logic [6:0]  seek_offset_i;
   logic        hdr_dv_i;
   logic [1:0]  hdr_i;
   logic        force_relock_i;
   logic [6:0]  offset_o;
   logic        offset_load_o;
   logic        locked_o;
   logic [1:0]  state_o;
   logic [15:0] relock_cnt_o;

   always #5 clk_i = ~clk_i;

   block_lock_ctrl dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .seek_dv_i      (seek_dv_i),
      .seek_offset_i  (seek_offset_i),
      .hdr_dv_i       (hdr_dv_i),
      .hdr_i          (hdr_i),
      .force_relock_i (force_relock_i),
      .offset_o       (offset_o),
      .offset_load_o  (offset_load_o),
      .locked_o       (locked_o),
      .state_o        (state_o),
      .relock_cnt_o   (relock_cnt_o)
   );

   typedef struct packed {
      logic [6:0]  offset;
      logic        load;
      logic        locked;
      logic [1:0]  state;
      logic [15:0] relock;
   } obs_t;

   obs_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   task automatic guard_expired(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: cycle budget expired", name);
   endtask

   // ---------------- reference model (phase: 0 hunt, 1 settle, 2 verify, 3 locked)
   int m_phase, m_cand, m_run, m_settle_left, m_good, m_win_blocks, m_win_bad;
   int m_offset, m_relocks;
   bit m_load;

   task automatic model_reset();
      m_phase = 0; m_cand = 0; m_run = 0; m_settle_left = 0; m_good = 0;
      m_win_blocks = 0; m_win_bad = 0; m_offset = 0; m_relocks = 0; m_load = 0;
   endtask

   task automatic enter_hunt();
      if (m_phase == 3 && m_relocks < 65535) m_relocks++;
      m_phase = 0;
      m_run   = 0;
   endtask

   task automatic model_step(input bit sdv, input int soff, input bit hdv,
                             input logic [1:0] hdr, input bit frc);
      bit good_hdr;
      good_hdr = (hdr == 2'b01) || (hdr == 2'b10);
      m_load   = 0;
      if (frc) begin
         enter_hunt();
         return;
      end
      case (m_phase)
         0: if (sdv) begin
            if (soff > 65)                      m_run = 0;
            else if (m_run > 0 && soff == m_cand) m_run++;
            else begin m_cand = soff; m_run = 1; end
            if (m_run == STABLE_CNT) begin
               m_offset = m_cand; m_load = 1; m_phase = 1; m_settle_left = SETTLE_CYC;
            end
         end
         1: begin
            m_settle_left--;
            if (m_settle_left == 0) begin m_phase = 2; m_good = 0; end
         end
         2: if (hdv) begin
            if (!good_hdr) enter_hunt();
            else begin
               m_good++;
               if (m_good == VERIFY_CNT) begin m_phase = 3; m_win_blocks = 0; m_win_bad = 0; end
            end
         end
         default: if (hdv) begin
            if (!good_hdr) m_win_bad++;
            if (m_win_bad == MAX_BAD) enter_hunt();
            else begin
               m_win_blocks++;
               if (m_win_blocks == WIN_LEN) begin m_win_blocks = 0; m_win_bad = 0; end
            end
         end
      endcase
   endtask

   function automatic obs_t model_obs();
      obs_t o;
      o.offset = 7'(m_offset);
      o.load   = m_load;
      o.locked = (m_phase == 3);
      o.state  = 2'(m_phase);
`ifdef BLOCK_LOCK_STATS_EN
      o.relock = 16'(m_relocks);
`else
      o.relock = 16'd0;
`endif
      return o;
   endfunction

   // ---------------- driver helpers
   function automatic logic [1:0] rand_good();
      return ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
   endfunction

   function automatic logic [1:0] rand_bad();
      return ($urandom_range(0, 1) != 0) ? 2'b00 : 2'b11;
   endfunction

   task automatic drive(input bit sdv, input int soff, input bit hdv,
                        input logic [1:0] hdr, input bit frc);
      @(negedge clk_i);
      seek_dv_i      = sdv;
      seek_offset_i  = 7'(soff);
      hdr_dv_i       = hdv;
      hdr_i          = hdr;
      force_relock_i = frc;
      model_step(sdv, soff, hdv, hdr, frc);
      exp_q.push_back(model_obs());
   endtask

   // Idle cycle carrying only traffic the current phase must ignore.
   task automatic gap_cycle();
      bit sdv, hdv;
      sdv = (m_phase >= 2) && ($urandom_range(0, 1) != 0);
      hdv = (m_phase <= 1) && ($urandom_range(0, 1) != 0);
      drive(sdv, $urandom_range(0, 127), hdv, 2'($urandom_range(0, 3)), 1'b0);
   endtask

   task automatic acquire(input int off);
      int guard = 0;
      while (m_phase == 0 && guard < 300) begin
         if ($urandom_range(0, 3) == 0) gap_cycle();
         else drive(1'b1, off, $urandom_range(0, 1) != 0, 2'($urandom_range(0, 3)), 1'b0);
         guard++;
      end
      if (guard >= 300) guard_expired("acquire");
   endtask

   task automatic settle_out();
      int guard = 0;
      while (m_phase == 1 && guard < 20) begin
         gap_cycle();
         guard++;
      end
      if (guard >= 20) guard_expired("settle");
   endtask

   task automatic verify_good(input int n);
      for (int i = 0; i < n; i++) begin
         while ($urandom_range(0, 3) == 0) gap_cycle();
         drive($urandom_range(0, 1) != 0, $urandom_range(0, 127), 1'b1, rand_good(), 1'b0);
      end
   endtask

   task automatic lock_on(input int off);
      acquire(off);
      settle_out();
      verify_good(VERIFY_CNT);
      if (m_phase != 3) guard_expired("lock_on");
   endtask

   // One full window with n_bad bad headers at random positions within [lo,hi].
   task automatic send_window(input int lo, input int hi, input int n_bad);
      bit bad_at [WIN_LEN];
      int idx[$];
      for (int i = 0; i < WIN_LEN; i++) bad_at[i] = 1'b0;
      for (int i = lo; i <= hi; i++) idx.push_back(i);
      for (int k = 0; k < n_bad; k++) begin
         int j;
         j = int'($urandom_range(0, idx.size() - 1));
         bad_at[idx[j]] = 1'b1;
         idx.delete(j);
      end
      for (int b = 0; b < WIN_LEN; b++) begin
         while ($urandom_range(0, 3) == 0) gap_cycle();
         drive($urandom_range(0, 1) != 0, $urandom_range(0, 127), 1'b1,
               bad_at[b] ? rand_bad() : rand_good(), 1'b0);
      end
   endtask

   // ---------------- monitor: compare every cycle the driver has queued an expectation
   initial begin : monitor
      obs_t e, a;
      int   cyc = 0;
      logic prev_load = 1'b0;
      forever begin
         @(posedge clk_i);
         #1;
         cyc++;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '{offset: offset_o, load: offset_load_o, locked: locked_o,
                  state: state_o, relock: relock_cnt_o};
            check($sformatf("cycle%0d {offset,load,locked,state,relock}", cyc), 32'(a), 32'(e));
            check($sformatf("cycle%0d load_back_to_back", cyc), 32'(prev_load & offset_load_o), 32'd0);
         end
         prev_load = offset_load_o;
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- stimulus
   initial begin : driver
      int unstable [15] = '{23, 23, 23, 24, 24, 24, 24, 70, 24, 24, 24, 24, 24, 24, 24};
      int cur_off, bad_pct;
      rst_ni = 1'b0; seek_dv_i = 1'b0; seek_offset_i = '0;
      hdr_dv_i = 1'b0; hdr_i = 2'b00; force_relock_i = 1'b0;
      model_reset();
      repeat (2) @(posedge clk_i);
      #1;
      check("reset offset_o", 32'(offset_o), 32'd0);
      check("reset offset_load_o", 32'(offset_load_o), 32'd0);
      check("reset locked_o", 32'(locked_o), 32'd0);
      check("reset state_o", 32'(state_o), 32'd0);
      check("reset relock_cnt_o", 32'(relock_cnt_o), 32'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;

      // Stable acquisition at 23, then error-window boundaries.
      lock_on(23);
      send_window(0, WIN_LEN - 1, MAX_BAD - 1);
      send_window(WIN_LEN - 8, WIN_LEN - 1, 8);
      send_window(0, 7, 8);
      send_window(0, WIN_LEN - 1, MAX_BAD);

      // Unstable seeker with an illegal offset, then a verify failure.
      foreach (unstable[i]) drive(1'b1, unstable[i], 1'b0, 2'b00, 1'b0);
      acquire(24);
      settle_out();
      verify_good(10);
      drive(1'b0, 0, 1'b1, 2'b11, 1'b0);
      repeat (3) gap_cycle();

      // Forced relock while locked, then while settling, then held as a level.
      lock_on(40);
      drive(1'b1, 40, 1'b1, rand_good(), 1'b1);
      acquire(41);
      drive(1'b0, 0, 1'b0, 2'b00, 1'b1);
      repeat (4) drive(1'b1, 41, 1'b1, rand_good(), 1'b1);
      repeat (2) gap_cycle();

      // Async reset in the middle of VERIFY, then reacquisition.
      acquire(12);
      settle_out();
      verify_good(5);
      @(posedge clk_i);
      #2;
      rst_ni = 1'b0; seek_dv_i = 1'b0; hdr_dv_i = 1'b0; force_relock_i = 1'b0;
      #1;
      check("async_rst offset_o", 32'(offset_o), 32'd0);
      check("async_rst locked_o", 32'(locked_o), 32'd0);
      check("async_rst state_o", 32'(state_o), 32'd0);
      check("async_rst relock_cnt_o", 32'(relock_cnt_o), 32'd0);
      model_reset();
      @(negedge clk_i);
      @(negedge clk_i);
      rst_ni = 1'b1;
      lock_on(65);
      send_window(0, WIN_LEN - 1, MAX_BAD);

      // Random soak alternating clean and noisy header segments.
      cur_off = int'($urandom_range(0, 65));
      for (int i = 0; i < 4000; i++) begin
         bit sdv, hdv, frc;
         int soff;
         bad_pct = ((i / 500) % 2 != 0) ? 30 : 1;
         if ($urandom_range(0, 199) == 0) cur_off = int'($urandom_range(0, 65));
         sdv  = $urandom_range(0, 1) != 0;
         soff = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 127)) : cur_off;
         hdv  = $urandom_range(0, 3) != 0;
         frc  = $urandom_range(0, 299) == 0;
         drive(sdv, soff, hdv, (int'($urandom_range(0, 99)) < bad_pct) ? rand_bad() : rand_good(), frc);
      end

      drive(1'b0, 0, 1'b0, 2'b00, 1'b0);
      @(posedge clk_i);
      #2;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
